// File: rtl/pwm_period_sequencer_if.sv
// Control/status bundle between a PWM channel owner and its period sequencer.
// The master drives enable and the shadow-load request; the sequencer reports counter and PWM state.
interface pwm_period_sequencer_if #(parameter int N = 7);
    logic         en;
    logic         load;
    logic [N-1:0] duty_in;
    logic [N-1:0] period_in;
    logic         load_ack;
    logic         pend;
    logic         pwm_out;
    logic [N-1:0] cnt;
    logic         period_end;

    modport master (
        output en, load, duty_in, period_in,
        input  load_ack, pend, pwm_out, cnt, period_end
    );

    modport slave (
        input  en, load, duty_in, period_in,
        output load_ack, pend, pwm_out, cnt, period_end
    );
endinterface

// File: rtl/pwm_period_sequencer.sv
// PWM period counter with double-buffered duty/period registers applied at wrap.
// PWM edges come from equality compares only (cnt == period, cnt+1 == duty).
module pwm_period_sequencer #(
    parameter int N = 7
) (
    input  logic                    clk,
    input  logic                    rst_n,
    pwm_period_sequencer_if.slave   bus
);

    logic [N-1:0] cnt_q, cnt_inc;
    logic [N-1:0] duty_act, per_act, duty_sh, per_sh, duty_nxt;
    logic         pend_q, ack_q, pwm_q, pe_q, hi_q, hi_nxt;
    logic         wrap, accept;

    // hi_q is the PWM level the counter position implies; it survives en=0
    // so the output can resume correctly while pwm_out itself is forced low.
    always_comb begin
        wrap     = (cnt_q == per_act);
        accept   = bus.load && !pend_q;
        cnt_inc  = cnt_q + {{(N-1){1'b0}}, 1'b1};
        duty_nxt = pend_q ? duty_sh : duty_act;
        hi_nxt   = hi_q;
        if (wrap)
            hi_nxt = (duty_nxt != '0);
        else if (cnt_inc == duty_act)
            hi_nxt = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            duty_act <= '0;
            duty_sh  <= '0;
            per_act  <= '1;
            per_sh   <= '1;
            pend_q   <= 1'b0;
            ack_q    <= 1'b0;
            pwm_q    <= 1'b0;
            pe_q     <= 1'b0;
            hi_q     <= 1'b0;
        end else begin
            ack_q <= accept;
            if (accept) begin
                duty_sh <= bus.duty_in;
                per_sh  <= bus.period_in;
            end

            // A transfer at wrap and a new accept are mutually exclusive on pend_q.
            if (bus.en && wrap && pend_q)
                pend_q <= 1'b0;
            else if (accept)
                pend_q <= 1'b1;

            if (bus.en) begin
                hi_q  <= hi_nxt;
                pwm_q <= hi_nxt;
                if (wrap) begin
                    cnt_q <= '0;
                    pe_q  <= 1'b1;
                    if (pend_q) begin
                        duty_act <= duty_sh;
                        per_act  <= per_sh;
                    end
                end else begin
                    cnt_q <= cnt_inc;
                    pe_q  <= 1'b0;
                end
            end else begin
                pe_q  <= 1'b0;
                pwm_q <= 1'b0;
            end
        end
    end

    assign bus.cnt        = cnt_q;
    assign bus.pwm_out    = pwm_q;
    assign bus.period_end = pe_q;
    assign bus.pend       = pend_q;
    assign bus.load_ack   = ack_q;

endmodule

// File: tb/tb_pwm_period_sequencer.sv
// Directed bench for pwm_period_sequencer: hand-computed expectations for reset,
// load handshake, duty/period extremes, enable gating and wrap coincidences.
module tb_pwm_period_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    pwm_period_sequencer_if #(.N(7)) bus();

    pwm_period_sequencer #(.N(7)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input int d, input int p, input string tag);
        bus.load      = 1'b1;
        bus.duty_in   = 7'(d);
        bus.period_in = 7'(p);
        tick();
        chk({tag, "_ack"}, bus.load_ack, 1);
        chk({tag, "_pend"}, bus.pend, 1);
        bus.load = 1'b0;
    endtask

    task automatic wait_pe(input string tag);
        int n = 0;
        do begin
            tick();
            n++;
        end while (!bus.period_end && n < 300);
        chk({tag, "_wrap_seen"}, bus.period_end, 1);
    endtask

    // Call right after a wrap sample; returns period length and high cycles in it.
    task automatic measure(output int len, output int highs);
        highs = int'(bus.pwm_out);
        len   = 0;
        do begin
            tick();
            len++;
            if (!bus.period_end) highs += int'(bus.pwm_out);
        end while (!bus.period_end && len < 300);
    endtask

    initial begin
        int len, highs, n, pe_cnt, hi_cnt;
        bus.en = 1'b0;
        bus.load = 1'b0;
        bus.duty_in = '0;
        bus.period_in = '0;

        #12;
        chk("rst_cnt", bus.cnt, 0);
        chk("rst_pwm", bus.pwm_out, 0);
        chk("rst_pe", bus.period_end, 0);
        chk("rst_ack", bus.load_ack, 0);
        chk("rst_pend", bus.pend, 0);
        rst_n = 1'b1;
        bus.en = 1'b1;

        // default period 127 -> first wrap on the 128th enabled edge
        n = 0;
        do begin
            tick();
            n++;
        end while (!bus.period_end && n < 300);
        chk("first_wrap_cycles", n, 128);
        chk("first_wrap_pwm", bus.pwm_out, 0);

        // basic (3,9)
        do_load(3, 9, "basic");
        tick();
        chk("basic_ack_once", bus.load_ack, 0);
        chk("basic_pend_held", bus.pend, 1);
        wait_pe("basic");
        chk("basic_pend_clr", bus.pend, 0);
        chk("basic_pwm_at0", bus.pwm_out, 1);
        pe_cnt = 0;
        hi_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            pe_cnt += int'(bus.period_end);
            hi_cnt += int'(bus.pwm_out);
        end
        chk("basic_pe_20cyc", pe_cnt, 2);
        chk("basic_hi_20cyc", hi_cnt, 6);
        chk("basic_cnt_end", bus.cnt, 0);

        // rejection while pending
        do_load(3, 9, "rej1");
        bus.load = 1'b1;
        bus.duty_in = 7'd5;
        bus.period_in = 7'd6;
        tick();
        chk("rej_no_ack", bus.load_ack, 0);
        bus.load = 1'b0;
        wait_pe("rej");
        measure(len, highs);
        chk("rej_len", len, 10);
        chk("rej_highs", highs, 3);
        do_load(5, 6, "retry");
        wait_pe("retry");
        measure(len, highs);
        chk("retry_len", len, 7);
        chk("retry_highs", highs, 5);

        // extremes
        do_load(0, 9, "d0");
        wait_pe("d0");
        measure(len, highs);
        chk("d0_len", len, 10);
        chk("d0_highs", highs, 0);
        do_load(12, 9, "d12");
        wait_pe("d12");
        measure(len, highs);
        chk("d12_len", len, 10);
        chk("d12_highs", highs, 10);
        do_load(1, 0, "p0");
        wait_pe("p0");
        pe_cnt = 0;
        hi_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            pe_cnt += int'(bus.period_end);
            hi_cnt += int'(bus.pwm_out);
        end
        chk("p0_pe", pe_cnt, 5);
        chk("p0_pwm", hi_cnt, 5);

        // enable gating with duty 8, period 9
        do_load(8, 9, "gate");
        wait_pe("gate");
        for (int i = 0; i < 5; i++) tick();
        chk("gate_cnt5", bus.cnt, 5);
        chk("gate_pwm5", bus.pwm_out, 1);
        bus.en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("gate_hold_cnt", bus.cnt, 5);
            chk("gate_hold_pwm", bus.pwm_out, 0);
            chk("gate_hold_pe", bus.period_end, 0);
        end
        bus.en = 1'b1;
        tick();
        chk("gate_cnt6", bus.cnt, 6);
        chk("gate_pwm6", bus.pwm_out, 1);
        tick();
        chk("gate_pwm7", bus.pwm_out, 1);
        tick();
        chk("gate_cnt8", bus.cnt, 8);
        chk("gate_pwm8", bus.pwm_out, 0);

        // load on the wrap edge with pend=0
        tick();
        chk("coin_cnt9", bus.cnt, 9);
        do_load(2, 4, "coin");
        chk("coin_pe", bus.period_end, 1);
        chk("coin_pwm_old", bus.pwm_out, 1);
        measure(len, highs);
        chk("coin_old_len", len, 10);
        chk("coin_old_highs", highs, 8);
        chk("coin_pend_clr", bus.pend, 0);
        measure(len, highs);
        chk("coin_new_len", len, 5);
        chk("coin_new_highs", highs, 2);

        // load on the wrap edge with pend=1: transfer happens, load ignored
        do_load(3, 4, "cp");
        for (int i = 0; i < 3; i++) tick();
        chk("cp_cnt4", bus.cnt, 4);
        bus.load = 1'b1;
        bus.duty_in = 7'd1;
        bus.period_in = 7'd4;
        tick();
        bus.load = 1'b0;
        chk("cp_pe", bus.period_end, 1);
        chk("cp_pend", bus.pend, 0);
        chk("cp_no_ack", bus.load_ack, 0);
        measure(len, highs);
        chk("cp_len", len, 5);
        chk("cp_highs", highs, 3);

        // asynchronous reset mid-run at cnt=40, pwm high
        do_load(60, 127, "ar");
        wait_pe("ar");
        for (int i = 0; i < 40; i++) tick();
        chk("ar_pre_cnt", bus.cnt, 40);
        chk("ar_pre_pwm", bus.pwm_out, 1);
        do_load(5, 9, "ar2");
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_cnt", bus.cnt, 0);
        chk("ar_pwm", bus.pwm_out, 0);
        chk("ar_pend", bus.pend, 0);
        chk("ar_ack", bus.load_ack, 0);
        #10;
        rst_n = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
